// File: rtl/debounce_sync.sv
// debounce_sync: input conditioning for a raw asynchronous level.
// The input passes through a SYNC_STAGES flop synchroniser. A change is
// accepted only after the synchronised level has differed from the current
// output for DEBOUNCE_CYCLES consecutive clocks. The stage then presents a
// clean level (q/qb) and single-cycle rise/fall pulses, and busy is high
// while a candidate change is being qualified.
// Optional feature: define DEBOUNCE_LONG_PRESS_EN to enable a one-shot
// long_press pulse after q has been held high for LONG_CYCLES clocks.
// Without that macro, long_press is tied to 0.
module debounce_sync #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = 16,
    parameter bit          RESET_LEVEL     = 1'b0,
    parameter int unsigned LONG_CYCLES     = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic qb,
    output logic rise,
    output logic fall,
    output logic busy,
    output logic long_press
);

    // FSM encoding
    localparam logic [1:0] ST_STABLE_LO = 2'd0;
    localparam logic [1:0] ST_STABLE_HI = 2'd1;
    localparam logic [1:0] ST_WAIT_HI   = 2'd2;
    localparam logic [1:0] ST_WAIT_LO   = 2'd3;

    localparam logic [1:0]       RST_STATE = RESET_LEVEL ? ST_STABLE_HI : ST_STABLE_LO;
    localparam bit               DEB_ONE   = (DEBOUNCE_CYCLES == 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    // Count value on which the final qualifying cycle commits the new level.
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Reject illegal configurations at elaboration.
    if ((SYNC_STAGES < 2) || (SYNC_STAGES > 4) ||
        (DEBOUNCE_CYCLES < 1) || ((DEBOUNCE_CYCLES >> CNT_W) != 0) ||
        (LONG_CYCLES < 1) || ((LONG_CYCLES >> CNT_W) != 0)) begin : g_bad_params
        $error("debounce_sync: illegal parameter combination");
    end

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_ds;
    logic [1:0]             r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_q;
    logic                   r_rise;
    logic                   r_fall;

    assign w_ds = r_sync[SYNC_STAGES-1];

    // Synchroniser chain: the only logic that samples the raw input d.
    // NOTE: the chain is reset to RESET_LEVEL so the FSM never sees X or a phantom edge after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {SYNC_STAGES{RESET_LEVEL}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], d};
        end
    end

    // Debounce FSM: qualifies each candidate change and emits the edge pulses.
    // NOTE: all state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RST_STATE;
            r_cnt   <= '0;
            r_q     <= RESET_LEVEL;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            case (r_state)
                ST_STABLE_LO: begin
                    if (w_ds) begin
                        if (DEB_ONE) begin
                            r_state <= ST_STABLE_HI;
                            r_q     <= 1'b1;
                            r_rise  <= 1'b1;
                        end else begin
                            r_state <= ST_WAIT_HI;
                            r_cnt   <= CNT_ONE;
                        end
                    end
                end
                ST_STABLE_HI: begin
                    if (!w_ds) begin
                        if (DEB_ONE) begin
                            r_state <= ST_STABLE_LO;
                            r_q     <= 1'b0;
                            r_fall  <= 1'b1;
                        end else begin
                            r_state <= ST_WAIT_LO;
                            r_cnt   <= CNT_ONE;
                        end
                    end
                end
                ST_WAIT_HI: begin
                    if (!w_ds) begin
                        // Bounce: drop back without touching the output.
                        r_state <= ST_STABLE_LO;
                        r_cnt   <= '0;
                    end else if (r_cnt >= DEB_LAST) begin
                        r_state <= ST_STABLE_HI;
                        r_cnt   <= '0;
                        r_q     <= 1'b1;
                        r_rise  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_WAIT_LO: begin
                    if (w_ds) begin
                        r_state <= ST_STABLE_HI;
                        r_cnt   <= '0;
                    end else if (r_cnt >= DEB_LAST) begin
                        r_state <= ST_STABLE_LO;
                        r_cnt   <= '0;
                        r_q     <= 1'b0;
                        r_fall  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= r_q ? ST_STABLE_HI : ST_STABLE_LO;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign q    = r_q;
    assign qb   = ~r_q;
    assign rise = r_rise;
    assign fall = r_fall;
    assign busy = (r_state == ST_WAIT_HI) || (r_state == ST_WAIT_LO);

`ifdef DEBOUNCE_LONG_PRESS_EN
    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(LONG_CYCLES - 1);

    logic [CNT_W-1:0] r_lp_cnt;
    logic             r_long_press;

    // Long-press timer: counts clocks spent staying in STABLE_HI, fires once, then saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lp_cnt     <= '0;
            r_long_press <= 1'b0;
        end else begin
            r_long_press <= 1'b0;
            if ((r_state == ST_STABLE_HI) && w_ds) begin
                if (r_lp_cnt < LP_LAST) begin
                    r_lp_cnt <= r_lp_cnt + 1'b1;
                end else if (r_lp_cnt == LP_LAST) begin
                    r_lp_cnt     <= r_lp_cnt + 1'b1;
                    r_long_press <= 1'b1;
                end
            end else begin
                r_lp_cnt <= '0;
            end
        end
    end

    assign long_press = r_long_press;
`else
    assign long_press = 1'b0;
`endif

endmodule

// File: tb/tb_debounce_sync.sv
// Self-checking bench for debounce_sync (SYNC_STAGES=2, DEBOUNCE_CYCLES=4,
// LONG_CYCLES=10). The reference model describes the behaviour as run
// lengths: the input is delayed by the synchroniser depth, and the output
// follows once the delayed input has disagreed with it for DEBOUNCE_CYCLES
// consecutive clocks.
module tb_debounce_sync;

    localparam int unsigned SYNC  = 2;
    localparam int unsigned DEB   = 4;
    localparam int unsigned LONGC = 10;

    logic clk = 1'b0;
    logic rst_n;
    logic d;
    logic q, qb, rise, fall, busy, long_press;
    logic [5:0] act;

    int checks = 0;
    int errors = 0;

    debounce_sync #(
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W          (16),
        .RESET_LEVEL    (1'b0),
        .LONG_CYCLES    (LONGC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .d         (d),
        .q         (q),
        .qb        (qb),
        .rise      (rise),
        .fall      (fall),
        .busy      (busy),
        .long_press(long_press)
    );

    always #5 clk = ~clk;

    assign act = {q, qb, rise, fall, busy, long_press};

    // Reference model state
    bit m_dly [SYNC];
    bit m_q, m_rise, m_fall, m_busy, m_lp;
    int m_run;
    int m_hold;

    task automatic model_reset();
        foreach (m_dly[i]) m_dly[i] = 1'b0;
        m_q    = 1'b0;
        m_rise = 1'b0;
        m_fall = 1'b0;
        m_busy = 1'b0;
        m_lp   = 1'b0;
        m_run  = 0;
        m_hold = 0;
    endtask

    task automatic model_step(input bit din);
        bit seen;
        bit was_stable_hi;
        seen = m_dly[SYNC-1];
        for (int i = SYNC - 1; i > 0; i--) m_dly[i] = m_dly[i-1];
        m_dly[0] = din;
        was_stable_hi = m_q && !m_busy;
        m_rise = 1'b0;
        m_fall = 1'b0;
        m_lp   = 1'b0;
        if (seen != m_q) begin
            m_run++;
            if (m_run == DEB) begin
                m_q    = seen;
                m_rise = seen;
                m_fall = !seen;
                m_run  = 0;
            end
        end else begin
            m_run = 0;
        end
        m_busy = (m_run != 0);
`ifdef DEBOUNCE_LONG_PRESS_EN
        if (was_stable_hi && m_q && !m_busy) begin
            m_hold++;
            if (m_hold == LONGC) m_lp = 1'b1;
        end else begin
            m_hold = 0;
        end
`else
        m_hold = was_stable_hi ? m_hold : 0;
`endif
    endtask

    function automatic logic [5:0] exp_vec();
        return {m_q, !m_q, m_rise, m_fall, m_busy, m_lp};
    endfunction

    // One clock: apply d, let the rising edge happen, advance the model, return at the falling edge.
    task automatic cycle(input logic dv);
        d = dv;
        @(posedge clk);
        if (rst_n) model_step(dv);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        d     = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (act !== 6'b010000) begin
            errors++;
            $display("FAIL reset_initial: got %b expected %b", act, 6'b010000);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            cycle(1'b1);
            checks++;
            if (act !== exp_vec()) begin
                errors++;
                $display("FAIL reset_prep cyc %0d: got %b expected %b", k, act, exp_vec());
            end
        end
        checks++;
        if (q !== 1'b1) begin
            errors++;
            $display("FAIL reset_prep_high: q=%b expected 1", q);
        end
        // Assert reset between edges; outputs must clear without a clock.
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (act !== 6'b010000) begin
            errors++;
            $display("FAIL reset_async: got %b expected %b", act, 6'b010000);
        end
        for (int k = 0; k < 2; k++) begin
            cycle(1'b0);
            checks++;
            if (act !== 6'b010000) begin
                errors++;
                $display("FAIL reset_hold cyc %0d: got %b expected %b", k, act, 6'b010000);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_clean_rise();
        repeat (4) cycle(1'b0);
        for (int k = 1; k <= 8; k++) begin
            cycle(1'b1);
            checks++;
            if (act !== exp_vec()) begin
                errors++;
                $display("FAIL clean_rise_model edge %0d: got %b expected %b", k, act, exp_vec());
            end
            checks++;
            if ({q, rise, busy} !== {(k >= 6), (k == 6), (k >= 3 && k <= 5)}) begin
                errors++;
                $display("FAIL clean_rise_timing edge %0d: q/rise/busy=%b%b%b expected %b%b%b",
                         k, q, rise, busy, (k >= 6), (k == 6), (k >= 3 && k <= 5));
            end
        end
    endtask

    task automatic test_bounce();
        int rises;
        int rise_edge;
        bit pat;
        rises     = 0;
        rise_edge = -1;
        repeat (10) cycle(1'b0);
        for (int k = 1; k <= 16; k++) begin
            pat = (k != 3);
            cycle(pat);
            checks++;
            if (act !== exp_vec()) begin
                errors++;
                $display("FAIL bounce_model edge %0d: got %b expected %b", k, act, exp_vec());
            end
            if (rise === 1'b1) begin
                rises++;
                rise_edge = k;
            end
        end
        checks++;
        if (rises != 1) begin
            errors++;
            $display("FAIL bounce_rise_count: got %0d expected 1", rises);
        end
        // Final run of ones starts at edge 4: 2 sync edges + 4 qualifying edges.
        checks++;
        if (rise_edge != 9) begin
            errors++;
            $display("FAIL bounce_rise_edge: got %0d expected 9", rise_edge);
        end
    endtask

    task automatic test_toggle_storm();
        int pulses;
        pulses = 0;
        repeat (3) cycle(1'b1);
        for (int i = 0; i < 40; i++) begin
            cycle(i % 2 == 1);
            checks++;
            if (act !== exp_vec()) begin
                errors++;
                $display("FAIL storm_model cyc %0d: got %b expected %b", i, act, exp_vec());
            end
            if (rise === 1'b1 || fall === 1'b1) pulses++;
            checks++;
            if (q !== 1'b1) begin
                errors++;
                $display("FAIL storm_q_hold cyc %0d: q=%b expected 1", i, q);
            end
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL storm_pulses: got %0d expected 0", pulses);
        end
        for (int k = 1; k <= 8; k++) begin
            cycle(1'b0);
            checks++;
            if (act !== exp_vec()) begin
                errors++;
                $display("FAIL storm_fall_model edge %0d: got %b expected %b", k, act, exp_vec());
            end
            checks++;
            if ({q, fall, rise} !== {(k < 6), (k == 6), 1'b0}) begin
                errors++;
                $display("FAIL storm_fall_timing edge %0d: q/fall/rise=%b%b%b expected %b%b0",
                         k, q, fall, rise, (k < 6), (k == 6));
            end
        end
    endtask

    task automatic test_reset_mid();
        repeat (4) cycle(1'b0);
        for (int k = 1; k <= 4; k++) begin
            cycle(1'b1);
            checks++;
            if (act !== exp_vec()) begin
                errors++;
                $display("FAIL rstmid_pre edge %0d: got %b expected %b", k, act, exp_vec());
            end
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (act !== 6'b010000) begin
            errors++;
            $display("FAIL rstmid_abort: got %b expected %b", act, 6'b010000);
        end
        for (int k = 0; k < 2; k++) begin
            cycle(1'b1);
            checks++;
            if (act !== 6'b010000) begin
                errors++;
                $display("FAIL rstmid_hold cyc %0d: got %b expected %b", k, act, 6'b010000);
            end
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            cycle(1'b1);
            checks++;
            if (act !== exp_vec()) begin
                errors++;
                $display("FAIL rstmid_post_model edge %0d: got %b expected %b", k, act, exp_vec());
            end
            checks++;
            if ({q, rise} !== {(k >= 6), (k == 6)}) begin
                errors++;
                $display("FAIL rstmid_rise_timing edge %0d: q/rise=%b%b expected %b%b",
                         k, q, rise, (k >= 6), (k == 6));
            end
        end
    endtask

    task automatic test_long_press();
        int rise_edge;
        int lp_edge;
        int lp_count;
        rise_edge = -1;
        lp_edge   = -1;
        lp_count  = 0;
        repeat (10) cycle(1'b0);
        for (int k = 1; k <= 40; k++) begin
            cycle(1'b1);
            checks++;
            if (act !== exp_vec()) begin
                errors++;
                $display("FAIL long_model edge %0d: got %b expected %b", k, act, exp_vec());
            end
            if (rise === 1'b1) rise_edge = k;
            if (long_press === 1'b1) begin
                lp_count++;
                lp_edge = k;
            end
        end
        checks++;
        if (rise_edge != 6) begin
            errors++;
            $display("FAIL long_rise_edge: got %0d expected 6", rise_edge);
        end
`ifdef DEBOUNCE_LONG_PRESS_EN
        checks++;
        if (lp_count != 1) begin
            errors++;
            $display("FAIL long_count: got %0d expected 1", lp_count);
        end
        checks++;
        if (lp_edge != 6 + LONGC) begin
            errors++;
            $display("FAIL long_edge: got %0d expected %0d", lp_edge, 6 + LONGC);
        end
`else
        checks++;
        if (lp_count != 0) begin
            errors++;
            $display("FAIL long_absent: got %0d pulses (last edge %0d) expected 0", lp_count, lp_edge);
        end
`endif
    endtask

    task automatic test_random();
        bit lvl;
        int run;
        lvl = 1'b0;
        for (int seg = 0; seg < 60; seg++) begin
            lvl = ~lvl;
            run = $urandom_range(1, 18);
            for (int k = 0; k < run; k++) begin
                cycle(lvl);
                checks++;
                if (act !== exp_vec()) begin
                    errors++;
                    $display("FAIL random seg %0d cyc %0d: got %b expected %b", seg, k, act, exp_vec());
                end
                checks++;
                if (rise === 1'b1 && fall === 1'b1) begin
                    errors++;
                    $display("FAIL random_both_pulses seg %0d: rise=%b fall=%b", seg, rise, fall);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_rise();
        test_bounce();
        test_toggle_storm();
        test_reset_mid();
        test_long_press();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
